// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit words from the flash over Avalon-MM and plays them out as two 16-bit
// audio samples per word, one per sample tick, walking the clip forward or backward.
module flash_audio_sequencer #(
  parameter int                 ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]  START_ADDR = 23'h0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              flash_read_finished,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              sample_valid
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    PLAY_FIRST,
    PLAY_SECOND,
    RESTART_DONE,
    RELEASE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              dir_q_reg, dir_q_next;
  logic [31:0]       word_reg, word_next;
  logic              tick_pending_reg, tick_pending_next;
  logic [15:0]       audio_reg, audio_next;
  logic              valid_reg, valid_next;

  logic              tick_go;
  logic              tick_in_fetch;
  logic [15:0]       first_half;
  logic [15:0]       second_half;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              backward);
    logic [ADDR_W-1:0] r;
    if (backward) begin
      r = (a == START_ADDR) ? END_ADDR : a - ADDR_ONE;
    end else begin
      r = (a == END_ADDR) ? START_ADDR : a + ADDR_ONE;
    end
    return r;
  endfunction

  // A tick is consumed either live or from the single-entry backlog left by a fetch.
  assign tick_go       = (sample_tick | tick_pending_reg) & play;
  assign tick_in_fetch = sample_tick & play;

  assign first_half  = dir_q_reg ? word_reg[31:16] : word_reg[15:0];
  assign second_half = dir_q_reg ? word_reg[15:0]  : word_reg[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      addr_reg         <= START_ADDR;
      dir_q_reg        <= 1'b0;
      word_reg         <= 32'h0;
      tick_pending_reg <= 1'b0;
      audio_reg        <= 16'h0;
      valid_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      dir_q_reg        <= dir_q_next;
      word_reg         <= word_next;
      tick_pending_reg <= tick_pending_next;
      audio_reg        <= audio_next;
      valid_reg        <= valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    dir_q_next        = dir_q_reg;
    word_next         = word_reg;
    tick_pending_next = tick_pending_reg;
    audio_next        = audio_reg;
    valid_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (restart) begin
          state_next = RESTART_DONE;
        end else if (play) begin
          dir_q_next = dir;
          state_next = REQ;
        end
      end

      REQ: begin
        if (tick_in_fetch) tick_pending_next = 1'b1;
        if (!flash_mem_waitrequest) state_next = WAIT_DATA;
      end

      // Restart is only honoured once the outstanding read has returned its data.
      WAIT_DATA: begin
        if (tick_in_fetch) tick_pending_next = 1'b1;
        if (flash_mem_readdatavalid) begin
          word_next  = flash_mem_readdata;
          state_next = restart ? RESTART_DONE : PLAY_FIRST;
        end
      end

      PLAY_FIRST: begin
        if (restart) begin
          state_next = RESTART_DONE;
        end else if (tick_go) begin
          audio_next        = first_half;
          valid_next        = 1'b1;
          tick_pending_next = 1'b0;
          state_next        = PLAY_SECOND;
        end
      end

      PLAY_SECOND: begin
        if (restart) begin
          state_next = RESTART_DONE;
        end else if (tick_go) begin
          audio_next        = second_half;
          valid_next        = 1'b1;
          tick_pending_next = 1'b0;
          addr_next         = step_addr(addr_reg, dir_q_reg);
          dir_q_next        = dir;
          state_next        = REQ;
        end
      end

      RESTART_DONE: begin
        addr_next         = dir ? END_ADDR : START_ADDR;
        tick_pending_next = 1'b0;
        state_next        = RELEASE;
      end

      RELEASE: begin
        if (!restart) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Decoded from the state register so that reset drops the read request at once.
  assign flash_mem_read       = (state_reg == REQ);
  assign flash_read_finished  = (state_reg == RESTART_DONE);
  assign flash_mem_address    = addr_reg;
  assign flash_mem_byteenable = 4'hF;
  assign audio_sample         = audio_reg;
  assign sample_valid         = valid_reg;

endmodule
